// File: rtl/ahb_native_mem_slave.sv
// AHB slave that forwards single transfers onto a PicoRV32-style native
// memory port. One transfer in flight at a time; wait states are inserted
// until the native target raises mem_ready. Unsupported sizes/alignments are
// answered with a two-cycle AHB ERROR and never reach the native port.
module ahb_native_mem_slave #(
  parameter bit BIG_ENDIAN_AHB = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DPH,
    S_MEM,
    S_ERR1,
    S_ERR2
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  // AHB big-endian byte lanes <-> native little-endian lanes.
  function automatic logic [31:0] lane_conv(input logic [31:0] d);
    if (BIG_ENDIAN_AHB) return {d[7:0], d[15:8], d[23:16], d[31:24]};
    else                return d;
  endfunction

  state_t      state, state_d;

  // Address-phase fields captured on accept.
  logic [31:0] cap_addr, cap_addr_d;
  logic        cap_write, cap_write_d;
  logic [1:0]  cap_size, cap_size_d;
  logic        cap_data, cap_data_d;

  logic        hreadyout_d;
  logic [1:0]  hresp_d;
  logic [31:0] hrdata_d;
  logic        mem_valid_d;
  logic        mem_instr_d;
  logic [31:0] mem_addr_d;
  logic [31:0] mem_wdata_d;
  logic [3:0]  mem_wstrb_d;

  logic        accept;
  logic        bad_access;
  logic [3:0]  strb;

  // Only NONSEQ/SEQ matter (htrans[1]); only the data/opcode bit of hprot is used.
  logic        unused;
  assign unused = ^{htrans[0], hprot[3:1]};

  assign accept     = (state == S_IDLE) && hsel && hready && htrans[1];
  assign bad_access = (hsize > 3'd2)
                   || ((hsize == 3'd1) && haddr[0])
                   || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));

  // Native byte strobes from the captured size and low address bits.
  always_comb begin
    strb = 4'b0000;
    if (cap_write) begin
      unique case (cap_size)
        2'd0:    strb = 4'b0001 << cap_addr[1:0];
        2'd1:    strb = 4'b0011 << cap_addr[1:0];
        default: strb = 4'b1111;
      endcase
    end
  end

  // Next-state and next-output logic for every registered signal.
  always_comb begin
    // NOTE: every *_d gets its hold value before the case, so no branch can leave one unassigned and infer a latch.
    state_d     = state;
    cap_addr_d  = cap_addr;
    cap_write_d = cap_write;
    cap_size_d  = cap_size;
    cap_data_d  = cap_data;
    hreadyout_d = hreadyout;
    hresp_d     = hresp;
    hrdata_d    = hrdata;
    mem_valid_d = mem_valid;
    mem_instr_d = mem_instr;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wstrb_d = mem_wstrb;

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          cap_addr_d  = haddr;
          cap_write_d = hwrite;
          cap_size_d  = hsize[1:0];
          cap_data_d  = hprot[0];
          hreadyout_d = 1'b0;
          if (bad_access) begin
            hresp_d = RESP_ERROR;
            state_d = S_ERR1;
          end else begin
            state_d = S_DPH;
          end
        end
      end
      S_DPH: begin
        // hwdata is valid now, one cycle after the address phase.
        if (cap_write) mem_wdata_d = lane_conv(hwdata);
        mem_addr_d  = {cap_addr[31:2], 2'b00};
        mem_wstrb_d = strb;
        mem_instr_d = ~cap_data;
        mem_valid_d = 1'b1;
        state_d     = S_MEM;
      end
      S_MEM: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          hreadyout_d = 1'b1;
          if (!cap_write) hrdata_d = lane_conv(mem_rdata);
          state_d = S_IDLE;
        end
      end
      S_ERR1: begin
        hreadyout_d = 1'b1;
        state_d     = S_ERR2;
      end
      S_ERR2: begin
        hresp_d = RESP_OKAY;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_size  <= '0;
      cap_data  <= 1'b0;
      hreadyout <= 1'b1;
      hresp     <= RESP_OKAY;
      hrdata    <= '0;
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state     <= state_d;
      cap_addr  <= cap_addr_d;
      cap_write <= cap_write_d;
      cap_size  <= cap_size_d;
      cap_data  <= cap_data_d;
      hreadyout <= hreadyout_d;
      hresp     <= hresp_d;
      hrdata    <= hrdata_d;
      mem_valid <= mem_valid_d;
      mem_instr <= mem_instr_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wstrb <= mem_wstrb_d;
    end
  end

endmodule

// File: tb/tb_ahb_native_mem_slave.sv
// Bench for ahb_native_mem_slave: a master driver issues AHB transfers and
// pushes expectations computed from a byte-addressed reference memory; a
// native responder and an AHB monitor pop and compare independently.
module tb_ahb_native_mem_slave;

  localparam bit BE = 1'b1;

  logic        clk;
  logic        resetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic        hready;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  // Single slave on the bus: bus HREADY is this slave's HREADYOUT.
  assign hready = hreadyout;

  ahb_native_mem_slave #(.BIG_ENDIAN_AHB(BE)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hprot     (hprot),
    .hready    (hready),
    .hwdata    (hwdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        write;
    logic [31:0] rdata;
    int          waits;
  } ahb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] mask;
    logic        instr;
  } nat_exp_t;

  ahb_exp_t ahb_q[$];
  nat_exp_t nat_q[$];
  int       dly_q[$];

  logic [7:0]  ref_bytes [0:1023];
  logic [31:0] mem_words [0:255];
  bit          force_late;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns just after the rising edge on which the current address phase is sampled.
  task automatic wait_accept(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (hready) break;
      n++;
      if (n > 64) begin
        checks++;
        errors++;
        $display("FAIL %s: hready stayed low for %0d cycles", name, n);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // One AHB transfer; the expectation comes from the byte-level reference memory.
  task automatic issue(input logic [31:0] addr, input logic write, input logic [2:0] size,
                       input logic [3:0] prot, input logic [31:0] wdata, input int dly);
    ahb_exp_t a;
    nat_exp_t n;
    logic     bad;
    int       wa;
    int       off;
    logic [7:0] b;
    bad = (size > 3'd2) || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
    a.err   = bad;
    a.write = write;
    a.rdata = '0;
    a.waits = bad ? 1 : 2 + dly;
    if (!bad) begin
      wa      = int'({addr[31:2], 2'b00});
      n.addr  = 32'(wa);
      n.strb  = '0;
      n.wdata = '0;
      n.mask  = '0;
      n.instr = ~prot[0];
      if (write) begin
        for (int i = 0; i < (1 << size); i++) begin
          off = int'(addr[1:0]) + i;
          b = BE ? wdata[31 - 8 * off -: 8] : wdata[8 * off +: 8];
          ref_bytes[wa + off] = b;
          n.strb[off] = 1'b1;
          n.wdata[8 * off +: 8] = b;
          n.mask[8 * off +: 8]  = 8'hFF;
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (BE) a.rdata[31 - 8 * k -: 8] = ref_bytes[wa + k];
          else    a.rdata[8 * k +: 8]      = ref_bytes[wa + k];
        end
      end
      nat_q.push_back(n);
      dly_q.push_back(dly);
    end
    ahb_q.push_back(a);
    hsel   = 1'b1;
    haddr  = addr;
    htrans = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10;
    hwrite = write;
    hsize  = size;
    hprot  = prot;
    wait_accept("accept");
    hsel   = 1'($urandom);
    htrans = 2'b00;
    haddr  = $urandom;
    hwdata = write ? wdata : $urandom;
    if (bad) wait_accept("err_done");
  endtask

  // A cycle with no transfer request (IDLE/BUSY, or NONSEQ while deselected).
  task automatic idle_beat(input logic sel, input logic [1:0] trans);
    hsel   = sel;
    htrans = trans;
    haddr  = $urandom;
    hwrite = 1'($urandom);
    hsize  = 3'd2;
    @(posedge clk);
    #1;
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic random_transfer();
    logic [31:0] addr;
    logic [2:0]  size;
    int          r;
    r = $urandom_range(0, 9);
    if (r < 3)      size = 3'd0;
    else if (r < 6) size = 3'd1;
    else if (r < 9) size = 3'd2;
    else            size = 3'($urandom_range(3, 7));
    addr = 32'($urandom_range(0, 1023));
    if ($urandom_range(0, 4) != 0) begin
      if (size == 3'd1) addr[0] = 1'b0;
      if (size == 3'd2) addr[1:0] = 2'b00;
    end
    issue(addr, 1'($urandom), size, 4'($urandom), $urandom, $urandom_range(0, 3));
  endtask

  // Native-side target: word memory with per-transfer response delay from dly_q.
  initial begin : responder
    nat_exp_t cur;
    bit       busy;
    int       cnt;
    logic [31:0] w;
    busy = 0;
    cnt  = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        busy = 0;
        mem_ready = 1'b0;
        continue;
      end
      if (mem_valid) begin
        if (!busy) begin
          busy = 1;
          if (nat_q.size() == 0 || dly_q.size() == 0) begin
            check("native_unexpected_req", 32'(mem_valid), 32'd0);
            cur = '{addr: mem_addr, strb: mem_wstrb, wdata: '0, mask: '0, instr: mem_instr};
            cnt = 0;
          end else begin
            cur = nat_q.pop_front();
            cnt = dly_q.pop_front();
            check("native_addr", mem_addr, cur.addr);
            check("native_wstrb", 32'(mem_wstrb), 32'(cur.strb));
            check("native_instr", 32'(mem_instr), 32'(cur.instr));
            check("native_wdata", mem_wdata & cur.mask, cur.wdata);
          end
        end else begin
          check("native_addr_stable", mem_addr, cur.addr);
          check("native_wstrb_stable", 32'(mem_wstrb), 32'(cur.strb));
          check("native_wdata_stable", mem_wdata & cur.mask, cur.wdata);
        end
        if (cnt == 0) begin
          w = mem_words[mem_addr[9:2]];
          mem_rdata = w;
          for (int k = 0; k < 4; k++)
            if (mem_wstrb[k]) w[8 * k +: 8] = mem_wdata[8 * k +: 8];
          mem_words[mem_addr[9:2]] = w;
          mem_ready = 1'b1;
          busy = 0;
        end else begin
          cnt--;
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        if (busy) begin
          check("native_req_dropped", 32'(mem_valid), 32'd1);
          busy = 0;
        end
        // mem_ready outside a request must be ignored, so toggle it freely.
        mem_ready = force_late ? 1'b1 : 1'($urandom);
        mem_rdata = $urandom;
      end
    end
  end

  // AHB-side monitor: counts wait states and checks each completing data phase.
  initial begin : ahb_monitor
    bit          active;
    int          waits;
    logic [31:0] last_rd;
    ahb_exp_t    e;
    active  = 0;
    waits   = 0;
    last_rd = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        active  = 0;
        waits   = 0;
        last_rd = '0;
        continue;
      end
      if (active) begin
        if (!hreadyout) begin
          waits++;
          if (ahb_q.size() != 0)
            check("wait_hresp", 32'(hresp), ahb_q[0].err ? 32'd1 : 32'd0);
        end else if (ahb_q.size() == 0) begin
          check("unexpected_response", 32'(hreadyout), 32'd0);
        end else begin
          e = ahb_q.pop_front();
          check("resp_hresp", 32'(hresp), e.err ? 32'd1 : 32'd0);
          check("resp_waits", 32'(waits), 32'(e.waits));
          if (!e.err && !e.write) begin
            check("read_hrdata", hrdata, e.rdata);
            last_rd = e.rdata;
          end else begin
            check("held_hrdata", hrdata, last_rd);
          end
        end
      end else begin
        check("idle_okay", 32'({hreadyout, hresp}), 32'b100);
      end
      if (hreadyout) begin
        active = hsel && htrans[1];
        waits  = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'h00;
    for (int i = 0; i < 256; i++)  mem_words[i] = 32'h0;
    force_late = 0;
    resetn = 1'b0;
    hsel   = 1'b0;
    haddr  = '0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hprot  = 4'b0001;
    hwdata = '0;

    @(negedge clk);
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_hresp",     32'(hresp),     32'd0);
    check("rst_hrdata",    hrdata,         32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_instr", 32'(mem_instr), 32'd0);
    check("rst_mem_addr",  mem_addr,       32'd0);
    check("rst_mem_wdata", mem_wdata,      32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) idle_beat(1'b0, 2'b00);

    // Directed cases.
    issue(32'h100, 1'b1, 3'd2, 4'b0011, 32'h1122_3344, 0);
    issue(32'h203, 1'b1, 3'd0, 4'b0011, 32'h0000_00AB, 0);
    issue(32'h300, 1'b1, 3'd2, 4'b0011, 32'hAABB_CCDD, 1);
    issue(32'h300, 1'b0, 3'd2, 4'b0000, 32'h0,         3);
    issue(32'h102, 1'b1, 3'd2, 4'b0011, 32'hDEAD_BEEF, 0);
    issue(32'h000, 1'b0, 3'd2, 4'b0001, 32'h0,         0);
    issue(32'h004, 1'b1, 3'd2, 4'b0001, 32'h5566_7788, 2);
    idle_beat(1'b1, 2'b01);
    idle_beat(1'b1, 2'b00);
    idle_beat(1'b0, 2'b10);
    issue(32'h101, 1'b0, 3'd1, 4'b0001, 32'h0,         0);
    issue(32'h102, 1'b0, 3'd1, 4'b0001, 32'h0,         1);
    issue(32'h100, 1'b0, 3'd3, 4'b0001, 32'h0,         0);

    // Randomized traffic, mixing back-to-back and gapped transfers.
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        n = $urandom_range(1, 2);
        for (int g = 0; g < n; g++)
          idle_beat(1'($urandom), ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b00);
      end
      random_transfer();
    end

    // Reset in the middle of a long native request.
    issue(32'h040, 1'b0, 3'd2, 4'b0011, 32'h0, 20);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre_reset_mem_valid", 32'(mem_valid), 32'd1);
    resetn = 1'b0;
    ahb_q.delete();
    nat_q.delete();
    dly_q.delete();
    #1;
    check("reset_mem_valid", 32'(mem_valid), 32'd0);
    check("reset_hreadyout", 32'(hreadyout), 32'd1);
    check("reset_hresp",     32'(hresp),     32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    force_late = 1;
    repeat (4) @(posedge clk);
    #1 force_late = 0;
    check("late_ready_no_req", 32'(mem_valid), 32'd0);

    for (int t = 0; t < 40; t++) random_transfer();
    issue(32'h300, 1'b0, 3'd2, 4'b0001, 32'h0, 0);

    n = 0;
    while ((ahb_q.size() != 0 || nat_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("ahb_queue_drained", 32'(ahb_q.size()), 32'd0);
    check("native_queue_drained", 32'(nat_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
